mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have clk, input, 1, system clock; all state changes on its rising edge.
REQ-002 SHALL have rst, input, 1, reset: synchronous, active-high.
REQ-003 SHALL have rdy, input, 1, global ready; when low, all state holds.
REQ-004 SHALL have ex_we, input, 1, register write enable from EX/MEM.
REQ-005 SHALL have ex_waddr, input, RegAddrBus (5), destination register.
REQ-006 SHALL have ex_wdata, input, RegBus (32), ALU result.
REQ-007 SHALL have ex_memop, input, MemOpBus (4), one of: NONE, LB, LH, LW, LBU, LHU, SB, SH, SW.
REQ-008 SHALL have ex_maddr, input, 32, effective byte address.
REQ-009 SHALL have ex_sdata, input, 32, store data.
REQ-010 SHALL have mc_req, output, 1, byte request to the memory controller.
REQ-011 SHALL have mc_wr, output, 1, 1 = write, 0 = read.
REQ-012 SHALL have mc_addr, output, 32, byte address.
REQ-013 SHALL have mc_wdata, output, 8, write byte.
REQ-014 SHALL have mc_rdata, input, 8, read byte, valid with mc_ack.
REQ-015 SHALL have mc_ack, input, 1, current byte complete.
REQ-016 SHALL have mem_we, output, 1, write enable to MEM/WB.
REQ-017 SHALL have mem_waddr, output, 5, destination to MEM/WB.
REQ-018 SHALL have mem_wdata, output, 32, write data to MEM/WB.
REQ-019 SHALL have stallreq, output, 1, pipeline stall request to the stall controller.

Function
REQ-020 SHALL implement FSM states IDLE, ACCESS and DONE.
REQ-021 In IDLE with memop NONE, outputs SHALL pass through combinationally: mem_we=ex_we, mem_waddr=ex_waddr, mem_wdata=ex_wdata, stallreq=0.
REQ-022 In IDLE with memop not NONE, stallreq SHALL be 1 combinationally and the next state SHALL be ACCESS; the block latches base address, store data, size N (1/2/4 for B/H/W), signedness, direction and ex_waddr/ex_we, and clears byte counter cnt.
REQ-023 In ACCESS, mc_req SHALL be 1, mc_addr=base+cnt (32-bit wrap), mc_wr=store, mc_wdata=store byte cnt (little-endian), stallreq=1.
REQ-024 On mc_ack in ACCESS, a load SHALL capture mc_rdata into byte lane cnt, and cnt SHALL increment.
REQ-025 On mc_ack with cnt=N-1, the next state SHALL be DONE; mc_req SHALL drop in the following cycle.
REQ-026 In DONE, stallreq SHALL be 0 and mc_req 0 for exactly one cycle, after which the next state SHALL be IDLE.
REQ-027 In DONE for a load: mem_we SHALL equal the latched we, and mem_wdata SHALL be the assembled value sign-extended (LB/LH) or zero-extended (LBU/LHU/LW) to 32 bits.
REQ-028 In DONE for a store: mem_we SHALL be 0, mem_waddr 0, and mem_wdata 0.
REQ-029 In IDLE and DONE, the registered mem outputs SHALL hold NOPRegAddr/ZeroWord whenever not driven per REQ-021..028.
REQ-030 mc_ack outside ACCESS SHALL be ignored.
REQ-031 Misaligned addresses SHALL be accessed bytewise with no trap.
REQ-032 With rdy=0, state, cnt and the captured data SHALL hold, and outputs SHALL remain stable.
REQ-033 Latency with mc_ack every cycle SHALL be N+2 cycles from op arrival to DONE output.

Reset
REQ-034 On rst=1 at a clock edge, the block SHALL enter IDLE, clear cnt and all latched data, and deassert mc_req and mc_wr; mc_addr and mc_wdata SHALL be 0.
REQ-035 A rst mid-ACCESS SHALL abandon the transfer, with no partial write-back.

Structure
REQ-036 MemOp encodings, RegAddrBus, RegBus, NOPRegAddr, ZeroWord, Enable and Disable SHALL reside in the shared defines file.
REQ-037 Load extension SHALL be a sub-module load_ext (combinational: size, sign, raw32 -> data32).

Verification
REQ-038 ADD, we=1, waddr=5, wdata=0x1234 -> same-cycle pass-through, stallreq=0, mc_req=0.
REQ-039 LB, addr 0x100, mc_rdata=0x80, ack next cycle -> DONE mem_wdata=0xFFFFFF80, waddr latched, 3-cycle latency.
REQ-040 LW, addr 0x203, bytes 11,22,33,44 at 0x203..0x206 -> mem_wdata=0x44332211, stallreq high for 5 cycles.
REQ-041 SW, sdata 0xA1B2C3D4, addr 0x10 -> mc_wr=1, bytes D4,C3,B2,A1 at 0x10..0x13, DONE mem_we=0.
REQ-042 LHU with ack gaps plus rdy=0 for 2 cycles -> counter holds, result 0x0000BEEF from EF,BE.
REQ-043 rst asserted after the first byte of SW -> next cycle IDLE, mc_req=0, no stale DONE output.

Source files
------------

// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
//  mem_access_pkg
//  Shared bus widths, NOP constants and memory-op encodings for the MEM stage.
//  Revision: 1.0
// ============================================================================
package mem_access_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_W      = 32;
   localparam int MEMOP_W    = 4;

   localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = 5'd0;
   localparam logic [REG_W-1:0]      ZERO_WORD    = 32'h0000_0000;
   localparam logic                  ENABLE       = 1'b1;
   localparam logic                  DISABLE      = 1'b0;

   localparam logic [MEMOP_W-1:0] MEMOP_NONE = 4'h0;
   localparam logic [MEMOP_W-1:0] MEMOP_LB   = 4'h1;
   localparam logic [MEMOP_W-1:0] MEMOP_LH   = 4'h2;
   localparam logic [MEMOP_W-1:0] MEMOP_LW   = 4'h3;
   localparam logic [MEMOP_W-1:0] MEMOP_LBU  = 4'h4;
   localparam logic [MEMOP_W-1:0] MEMOP_LHU  = 4'h5;
   localparam logic [MEMOP_W-1:0] MEMOP_SB   = 4'h6;
   localparam logic [MEMOP_W-1:0] MEMOP_SH   = 4'h7;
   localparam logic [MEMOP_W-1:0] MEMOP_SW   = 4'h8;

   typedef struct packed {
      logic       valid;
      logic       store;
      logic       sign;
      logic [2:0] size;
   } memop_info_t;

   // Unused encodings decode as "no memory op" so they pass straight through.
   function automatic memop_info_t decode_memop(input logic [MEMOP_W-1:0] op);
      memop_info_t info;
      info = '{valid: 1'b1, store: 1'b0, sign: 1'b0, size: 3'd4};
      case (op)
         MEMOP_LB:  begin info.sign  = 1'b1; info.size = 3'd1; end
         MEMOP_LH:  begin info.sign  = 1'b1; info.size = 3'd2; end
         MEMOP_LW:  info.size = 3'd4;
         MEMOP_LBU: info.size = 3'd1;
         MEMOP_LHU: info.size = 3'd2;
         MEMOP_SB:  begin info.store = 1'b1; info.size = 3'd1; end
         MEMOP_SH:  begin info.store = 1'b1; info.size = 3'd2; end
         MEMOP_SW:  info.store = 1'b1;
         default:   info.valid = 1'b0;
      endcase
      return info;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_load_ext.sv
`default_nettype none
// ============================================================================
//  load_ext
//  Sign/zero extension of an assembled load value to a full register word.
//  Revision: 1.0
// ============================================================================
module load_ext
   import mem_access_pkg::*;
(
   input  logic [2:0]       size,
   input  logic             sign,
   input  logic [REG_W-1:0] raw,
   output logic [REG_W-1:0] data
);

   always_comb begin
      data = raw;
      case (size)
         3'd1:    data = {{24{sign & raw[7]}},  raw[7:0]};
         3'd2:    data = {{16{sign & raw[15]}}, raw[15:0]};
         default: data = raw;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
//  mem_access
//  MEM stage: turns B/H/W loads and stores into byte-serial controller traffic.
//  Revision: 1.0
// ============================================================================
module mem_access
   import mem_access_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rdy,
   input  logic                  ex_we,
   input  logic [REG_ADDR_W-1:0] ex_waddr,
   input  logic [REG_W-1:0]      ex_wdata,
   input  logic [MEMOP_W-1:0]    ex_memop,
   input  logic [31:0]           ex_maddr,
   input  logic [31:0]           ex_sdata,
   output logic                  mc_req,
   output logic                  mc_wr,
   output logic [31:0]           mc_addr,
   output logic [7:0]            mc_wdata,
   input  logic [7:0]            mc_rdata,
   input  logic                  mc_ack,
   output logic                  mem_we,
   output logic [REG_ADDR_W-1:0] mem_waddr,
   output logic [REG_W-1:0]      mem_wdata,
   output logic                  stallreq
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [1:0]            cnt_q,   cnt_d;
   logic [31:0]           base_q,  base_d;
   logic [31:0]           sdata_q, sdata_d;
   logic [31:0]           raw_q,   raw_d;
   logic [2:0]            size_q,  size_d;
   logic                  sign_q,  sign_d;
   logic                  store_q, store_d;
   logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
   logic                  we_q,    we_d;

   memop_info_t           ex_info;
   logic                  last_byte;
   logic [REG_W-1:0]      load_data;

   assign ex_info   = decode_memop(ex_memop);
   assign last_byte = ({1'b0, cnt_q} == (size_q - 3'd1));

   load_ext u_load_ext (
      .size (size_q),
      .sign (sign_q),
      .raw  (raw_q),
      .data (load_data)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      base_d    = base_q;
      sdata_d   = sdata_q;
      raw_d     = raw_q;
      size_d    = size_q;
      sign_d    = sign_q;
      store_d   = store_q;
      waddr_d   = waddr_q;
      we_d      = we_q;

      mc_req    = DISABLE;
      mc_wr     = DISABLE;
      mc_addr   = 32'h0;
      mc_wdata  = 8'h00;
      mem_we    = DISABLE;
      mem_waddr = NOP_REG_ADDR;
      mem_wdata = ZERO_WORD;
      stallreq  = DISABLE;

      case (state_q)
         S_IDLE: begin
            if (ex_info.valid) begin
               stallreq = ENABLE;
               state_d  = S_ACCESS;
               base_d   = ex_maddr;
               sdata_d  = ex_sdata;
               raw_d    = ZERO_WORD;
               size_d   = ex_info.size;
               sign_d   = ex_info.sign;
               store_d  = ex_info.store;
               waddr_d  = ex_waddr;
               we_d     = ex_we;
               cnt_d    = 2'd0;
            end else begin
               mem_we    = ex_we;
               mem_waddr = ex_waddr;
               mem_wdata = ex_wdata;
            end
         end

         S_ACCESS: begin
            mc_req   = ENABLE;
            mc_wr    = store_q;
            mc_addr  = base_q + {30'd0, cnt_q};
            mc_wdata = sdata_q[{cnt_q, 3'b000} +: 8];
            stallreq = ENABLE;
            if (mc_ack) begin
               if (!store_q) begin
                  raw_d[{cnt_q, 3'b000} +: 8] = mc_rdata;
               end
               cnt_d = cnt_q + 2'd1;
               if (last_byte) begin
                  state_d = S_DONE;
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
            if (!store_q) begin
               mem_we    = we_q;
               mem_waddr = waddr_q;
               mem_wdata = load_data;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // A reset anywhere, including mid-transfer, drops every latched field.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 2'd0;
         base_q  <= 32'h0;
         sdata_q <= 32'h0;
         raw_q   <= ZERO_WORD;
         size_q  <= 3'd0;
         sign_q  <= 1'b0;
         store_q <= 1'b0;
         waddr_q <= NOP_REG_ADDR;
         we_q    <= DISABLE;
      end else if (rdy) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         base_q  <= base_d;
         sdata_q <= sdata_d;
         raw_q   <= raw_d;
         size_q  <= size_d;
         sign_q  <= sign_d;
         store_q <= store_d;
         waddr_q <= waddr_d;
         we_q    <= we_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
//  tb_mem_access
//  Directed bench for mem_access with hand-computed expected values.
//  Revision: 1.0
// ============================================================================
module tb_mem_access;
   import mem_access_pkg::*;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic        ex_we;
   logic [4:0]  ex_waddr;
   logic [31:0] ex_wdata;
   logic [3:0]  ex_memop;
   logic [31:0] ex_maddr;
   logic [31:0] ex_sdata;
   logic        mc_req;
   logic        mc_wr;
   logic [31:0] mc_addr;
   logic [7:0]  mc_wdata;
   logic [7:0]  mc_rdata;
   logic        mc_ack;
   logic        mem_we;
   logic [4:0]  mem_waddr;
   logic [31:0] mem_wdata;
   logic        stallreq;

   int n_checks = 0;
   int n_fail   = 0;

   mem_access dut (
      .clk       (clk),
      .rst       (rst),
      .rdy       (rdy),
      .ex_we     (ex_we),
      .ex_waddr  (ex_waddr),
      .ex_wdata  (ex_wdata),
      .ex_memop  (ex_memop),
      .ex_maddr  (ex_maddr),
      .ex_sdata  (ex_sdata),
      .mc_req    (mc_req),
      .mc_wr     (mc_wr),
      .mc_addr   (mc_addr),
      .mc_wdata  (mc_wdata),
      .mc_rdata  (mc_rdata),
      .mc_ack    (mc_ack),
      .mem_we    (mem_we),
      .mem_waddr (mem_waddr),
      .mem_wdata (mem_wdata),
      .stallreq  (stallreq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic go_idle();
      ex_memop = MEMOP_NONE;
      ex_we    = 1'b0;
      ex_waddr = 5'd0;
      ex_wdata = 32'h0;
      mc_ack   = 1'b0;
   endtask

   // One complete op: arrival cycle, n bytes each preceded by 'gap' idle cycles, then DONE.
   task automatic xfer(input string tag, input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic [31:0] rbytes, input int n,
                       input int gap, input logic exp_we, input logic [4:0] exp_waddr,
                       input logic [31:0] exp_wdata, input int exp_stall);
      int          stalls;
      logic [31:0] a;
      logic        st;
      st       = (op == MEMOP_SB) || (op == MEMOP_SH) || (op == MEMOP_SW);
      stalls   = 0;
      ex_memop = op;
      ex_maddr = addr;
      ex_sdata = sdata;
      ex_waddr = 5'd9;
      ex_we    = 1'b1;
      ex_wdata = 32'hDEAD_BEEF;
      mc_ack   = 1'b0;
      #1;
      chk({tag, "_arrive_stall"}, 32'(stallreq), 32'd1);
      chk({tag, "_arrive_memwe"}, 32'(mem_we), 32'd0);
      if (stallreq) stalls++;
      step();
      for (int i = 0; i < n; i++) begin
         a = addr + 32'(i);
         for (int g = 0; g < gap; g++) begin
            mc_ack = 1'b0;
            #1;
            chk({tag, "_gap_addr"}, mc_addr, a);
            if (stallreq) stalls++;
            step();
         end
         mc_ack   = 1'b1;
         mc_rdata = rbytes[i*8 +: 8];
         #1;
         chk({tag, "_req"},  32'(mc_req), 32'd1);
         chk({tag, "_addr"}, mc_addr, a);
         chk({tag, "_wr"},   32'(mc_wr), 32'(st));
         if (st) chk({tag, "_wbyte"}, 32'(mc_wdata), 32'(sdata[i*8 +: 8]));
         if (stallreq) stalls++;
         step();
      end
      mc_ack = 1'b0;
      #1;
      chk({tag, "_done_stall"}, 32'(stallreq), 32'd0);
      chk({tag, "_done_req"},   32'(mc_req), 32'd0);
      chk({tag, "_done_we"},    32'(mem_we), 32'(exp_we));
      chk({tag, "_done_waddr"}, 32'(mem_waddr), 32'(exp_waddr));
      chk({tag, "_done_wdata"}, mem_wdata, exp_wdata);
      chk({tag, "_stall_cyc"},  32'(stalls), 32'(exp_stall));
      step();
      go_idle();
      #1;
      chk({tag, "_idle_after"}, 32'(stallreq), 32'd0);
   endtask

   initial begin
      rst      = 1'b1;
      rdy      = 1'b1;
      ex_maddr = 32'h0;
      ex_sdata = 32'h0;
      mc_rdata = 8'h00;
      go_idle();
      step();
      step();
      chk("rst_req",   32'(mc_req),   32'd0);
      chk("rst_wr",    32'(mc_wr),    32'd0);
      chk("rst_addr",  mc_addr,       32'd0);
      chk("rst_wdata", 32'(mc_wdata), 32'd0);
      chk("rst_stall", 32'(stallreq), 32'd0);
      rst = 1'b0;

      // Non-memory op passes through in the same cycle.
      ex_memop = MEMOP_NONE;
      ex_we    = 1'b1;
      ex_waddr = 5'd5;
      ex_wdata = 32'h0000_1234;
      #1;
      chk("pass_we",    32'(mem_we),    32'd1);
      chk("pass_waddr", 32'(mem_waddr), 32'd5);
      chk("pass_wdata", mem_wdata,      32'h0000_1234);
      chk("pass_stall", 32'(stallreq),  32'd0);
      chk("pass_req",   32'(mc_req),    32'd0);
      step();
      go_idle();

      xfer("lb",  MEMOP_LB,  32'h0000_0100, 32'h0, 32'h0000_0080, 1, 0, 1'b1, 5'd9, 32'hFFFF_FF80, 2);
      xfer("lw",  MEMOP_LW,  32'h0000_0203, 32'h0, 32'h4433_2211, 4, 0, 1'b1, 5'd9, 32'h4433_2211, 5);
      xfer("sw",  MEMOP_SW,  32'h0000_0010, 32'hA1B2_C3D4, 32'h0, 4, 0, 1'b0, 5'd0, 32'h0, 5);
      xfer("lh",  MEMOP_LH,  32'hFFFF_FFFF, 32'h0, 32'h0000_F234, 2, 1, 1'b1, 5'd9, 32'hFFFF_F234, 5);
      xfer("lbu", MEMOP_LBU, 32'h0000_0055, 32'h0, 32'h0000_0080, 1, 2, 1'b1, 5'd9, 32'h0000_0080, 4);

      // LHU with ack gaps and two rdy=0 cycles during which an ack must be ignored.
      ex_memop = MEMOP_LHU;
      ex_maddr = 32'h0000_0040;
      ex_waddr = 5'd9;
      ex_we    = 1'b1;
      step();
      mc_ack = 1'b0;
      #1;
      chk("lhu_gap0", mc_addr, 32'h0000_0040);
      step();
      rdy      = 1'b0;
      mc_ack   = 1'b1;
      mc_rdata = 8'hEF;
      step();
      chk("lhu_hold_addr",  mc_addr, 32'h0000_0040);
      chk("lhu_hold_stall", 32'(stallreq), 32'd1);
      step();
      chk("lhu_hold_addr2", mc_addr, 32'h0000_0040);
      rdy = 1'b1;
      step();
      mc_ack = 1'b0;
      #1;
      chk("lhu_byte1_addr", mc_addr, 32'h0000_0041);
      step();
      mc_ack   = 1'b1;
      mc_rdata = 8'hBE;
      step();
      mc_ack = 1'b0;
      #1;
      chk("lhu_done_we",    32'(mem_we), 32'd1);
      chk("lhu_done_wdata", mem_wdata,   32'h0000_BEEF);
      step();
      go_idle();

      // Reset after the first SW byte abandons the transfer.
      ex_memop = MEMOP_SW;
      ex_maddr = 32'h0000_0010;
      ex_sdata = 32'hA1B2_C3D4;
      ex_waddr = 5'd3;
      ex_we    = 1'b1;
      step();
      mc_ack = 1'b1;
      step();
      mc_ack = 1'b0;
      rst    = 1'b1;
      #1;
      chk("rst_mid_addr", mc_addr, 32'h0000_0011);
      step();
      rst = 1'b0;
      go_idle();
      #1;
      chk("rst_mid_req",   32'(mc_req),   32'd0);
      chk("rst_mid_stall", 32'(stallreq), 32'd0);
      chk("rst_mid_addr0", mc_addr,       32'd0);
      step();
      chk("rst_no_done_we",    32'(mem_we), 32'd0);
      chk("rst_no_done_wdata", mem_wdata,   32'd0);
      chk("rst_no_done_req",   32'(mc_req), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
